cordic_iter_ctrl: RTL and testbench

- Iterative rotation-mode CORDIC sequencer on 22-bit signed x/y/z.
- Accepts one vector plus angle, runs ITER micro-rotations through one shared arithmetic-shift/add-sub datapath (one iteration per clock), then presents the rotated vector with a valid/ready handshake.
- Sits between the angle/phase source and downstream mixers/polar converters.

---
 rtl/cordic_pkg.sv | 26 ++
 rtl/cordic_atan_rom.sv | 19 +
 rtl/cordic_iter_ctrl.sv | 161 ++++++++++++++++
 tb/tb_cordic_iter_ctrl.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cordic_pkg.sv
// Shared constants, angle table and state type for the CORDIC sequencer.
// Optional gain compensation is selected with CORDIC_GAIN_COMP_EN.
package cordic_pkg;

  localparam int WIDTH_DEF = 22;
  localparam int ANGLE_PI  = 2**21;
  localparam int K_INV     = 39797;
  localparam int ATAN_N    = 20;

  // atan(2^-i) in units of pi/2^21
  localparam int ATAN_TAB [ATAN_N] = '{
    524288, 309506, 163534, 83012,
    41667,  20854,  10430,  5215,
    2608,   1304,   652,    326,
    163,    81,     41,     20,
    10,     5,      3,      1
  };

  typedef enum logic [1:0] {
    IDLE,
    ROT,
    COMP,
    DONE
  } state_t;

endpackage

// File: rtl/cordic_atan_rom.sv
// Combinational micro-rotation angle lookup.
// Indices past the table return zero.
import cordic_pkg::*;

module cordic_atan_rom #(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [4:0]       i_idx,
  output logic [WIDTH-1:0] o_angle
);

  always_comb begin
    o_angle = '0;
    if (i_idx < 5'(ATAN_N)) begin
      o_angle = WIDTH'(ATAN_TAB[i_idx]);
    end
  end

endmodule

// File: rtl/cordic_iter_ctrl.sv
// Iterative rotation-mode CORDIC, one micro-rotation per clock.
// Define CORDIC_GAIN_COMP_EN to add a 1/K scaling step before DONE.
import cordic_pkg::*;

module cordic_iter_ctrl #(
  parameter int WIDTH = WIDTH_DEF,
  parameter int ITER  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [WIDTH-1:0] x_in,
  input  logic signed [WIDTH-1:0] y_in,
  input  logic signed [WIDTH-1:0] z_in,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [WIDTH-1:0] x_out,
  output logic signed [WIDTH-1:0] y_out,
  output logic signed [WIDTH-1:0] z_out,
  output logic [4:0]              iter_cnt
);

  state_t r_state;
  state_t w_next;

  logic signed [WIDTH-1:0] r_x;
  logic signed [WIDTH-1:0] r_y;
  logic signed [WIDTH-1:0] r_z;
  logic [4:0]              r_cnt;

  logic                    w_last;
  logic                    w_neg;
  logic                    w_quad;
  logic [WIDTH-1:0]        w_atan;
  logic signed [WIDTH-1:0] w_xs;
  logic signed [WIDTH-1:0] w_ys;
  logic signed [WIDTH-1:0] w_xn;
  logic signed [WIDTH-1:0] w_yn;
  logic signed [WIDTH-1:0] w_zn;

  cordic_atan_rom #(
    .WIDTH (WIDTH)
  ) u_rom (
    .i_idx   (r_cnt),
    .o_angle (w_atan)
  );

  assign w_last = (r_cnt == 5'(ITER - 1));
  assign w_neg  = r_z[WIDTH-1];
  assign w_quad = z_in[WIDTH-1] ^ z_in[WIDTH-2];
  assign w_xs   = r_x >>> r_cnt;
  assign w_ys   = r_y >>> r_cnt;
  assign w_xn   = w_neg ? r_x + w_ys : r_x - w_ys;
  assign w_yn   = w_neg ? r_y - w_xs : r_y + w_xs;
  assign w_zn   = w_neg ? r_z + w_atan : r_z - w_atan;

`ifdef CORDIC_GAIN_COMP_EN
  localparam int PW = WIDTH + 17;

  logic signed [PW-1:0]    w_xe;
  logic signed [PW-1:0]    w_ye;
  logic signed [PW-1:0]    w_ke;
  logic signed [PW-1:0]    w_px;
  logic signed [PW-1:0]    w_py;
  logic signed [WIDTH-1:0] w_xk;
  logic signed [WIDTH-1:0] w_yk;

  assign w_xe = PW'(r_x);
  assign w_ye = PW'(r_y);
  assign w_ke = PW'(K_INV);
  assign w_px = w_xe * w_ke;
  assign w_py = w_ye * w_ke;
  // product is Q0.16 scaled; drop the fraction
  assign w_xk = WIDTH'(w_px >>> 16);
  assign w_yk = WIDTH'(w_py >>> 16);
`endif

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign iter_cnt  = r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: if (in_valid) w_next = ROT;
      ROT: begin
        if (w_last) begin
`ifdef CORDIC_GAIN_COMP_EN
          w_next = COMP;
`else
          w_next = DONE;
`endif
        end
      end
      COMP: w_next = DONE;
      DONE: if (out_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_x   <= '0;
      r_y   <= '0;
      r_z   <= '0;
      r_cnt <= '0;
      x_out <= '0;
      y_out <= '0;
      z_out <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_cnt <= '0;
            // fold |angle| >= pi/2 into range by a half turn
            if (w_quad) begin
              r_x <= -x_in;
              r_y <= -y_in;
              r_z <= z_in - WIDTH'(ANGLE_PI);
            end else begin
              r_x <= x_in;
              r_y <= y_in;
              r_z <= z_in;
            end
          end
        end
        ROT: begin
          r_x   <= w_xn;
          r_y   <= w_yn;
          r_z   <= w_zn;
          r_cnt <= w_last ? 5'd0 : r_cnt + 5'd1;
`ifndef CORDIC_GAIN_COMP_EN
          if (w_last) begin
            x_out <= w_xn;
            y_out <= w_yn;
            z_out <= w_zn;
          end
`endif
        end
`ifdef CORDIC_GAIN_COMP_EN
        COMP: begin
          x_out <= w_xk;
          y_out <= w_yk;
          z_out <= r_z;
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cordic_iter_ctrl.sv
// Randomised bench for cordic_iter_ctrl against a transaction-level model.
// Follows CORDIC_GAIN_COMP_EN to pick latency and output scaling.
module tb_cordic_iter_ctrl;

  localparam int ITER = 16;
`ifdef CORDIC_GAIN_COMP_EN
  localparam int LAT  = ITER + 2;
  localparam int KMAG = 262144;
`else
  localparam int LAT  = ITER + 1;
  localparam int KMAG = 431685;
`endif

  logic               clk = 0;
  logic               rst = 1;
  logic               in_valid = 0;
  logic               in_ready;
  logic signed [21:0] x_in = 0;
  logic signed [21:0] y_in = 0;
  logic signed [21:0] z_in = 0;
  logic               out_valid;
  logic               out_ready = 0;
  logic signed [21:0] x_out;
  logic signed [21:0] y_out;
  logic signed [21:0] z_out;
  logic [4:0]         iter_cnt;

  int checks = 0;
  int errors = 0;
  bit chk_en = 0;

  int atab [20];
  int age = 0;
  bit m_acc = 0;
  logic signed [21:0] ex = 0, ey = 0, ez = 0;
  logic signed [21:0] rx = 0, ry = 0, rz = 0;

  cordic_iter_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x_in      (x_in),
    .y_in      (y_in),
    .z_in      (z_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .x_out     (x_out),
    .y_out     (y_out),
    .z_out     (z_out),
    .iter_cnt  (iter_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    real p;
    p = 1.0;
    for (int i = 0; i < 20; i++) begin
      atab[i] = $rtoi($atan(p) * 2097152.0 / 3.141592653589793 + 0.5);
      p = p / 2.0;
    end
    // the reference table quotes 309506 for i=1
    atab[1] = 309506;
  end

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_near(input string nm, input longint act,
                          input longint exp, input longint tol);
    longint d;
    checks++;
    d = act - exp;
    if (d < 0) d = -d;
    if (d > tol) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d +/- %0d", nm, act, exp, tol);
    end
  endtask

  function automatic void cref(
    input  logic signed [21:0] xi, yi, zi,
    output logic signed [21:0] xo, yo, zo);
    logic signed [21:0] x, y, z, xs, ys;
    longint pr;
    x = xi;
    y = yi;
    z = zi;
    if (zi[21] != zi[20]) begin
      x = -xi;
      y = -yi;
      z = 22'(int'(zi) - 2097152);
    end
    for (int i = 0; i < ITER; i++) begin
      xs = x >>> i;
      ys = y >>> i;
      if (z >= 0) begin
        x = x - ys;
        y = y + xs;
        z = z - 22'(atab[i]);
      end else begin
        x = x + ys;
        y = y - xs;
        z = z + 22'(atab[i]);
      end
    end
`ifdef CORDIC_GAIN_COMP_EN
    pr = longint'(x) * 39797;
    x = 22'(pr >>> 16);
    pr = longint'(y) * 39797;
    y = 22'(pr >>> 16);
`else
    pr = 0;
`endif
    xo = x;
    yo = y;
    zo = z + 22'(pr - pr);
  endfunction

  // age: cycles since accept, 0 when idle
  always @(posedge clk) begin
    m_acc = 0;
    if (rst) begin
      age = 0;
      ex = 0;
      ey = 0;
      ez = 0;
    end else if (age == 0) begin
      if (in_valid) begin
        cref(x_in, y_in, z_in, rx, ry, rz);
        age = 1;
        m_acc = 1;
      end
    end else if (age >= LAT) begin
      if (out_ready) age = 0;
    end else begin
      age++;
      if (age == LAT) begin
        ex = rx;
        ey = ry;
        ez = rz;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("in_ready", in_ready, age == 0);
      chk("out_valid", out_valid, age >= LAT);
      chk("x_out", x_out, ex);
      chk("y_out", y_out, ey);
      chk("z_out", z_out, ez);
      if (age >= 1 && age <= ITER) chk("iter_cnt", iter_cnt, age - 1);
    end
  end

  task automatic accept(input logic signed [21:0] x, y, z);
    int n;
    n = 0;
    x_in = x;
    y_in = y;
    z_in = z;
    in_valid = 1;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!m_acc && n < 64);
    in_valid = 0;
    chk("accept_timeout", m_acc, 1);
  endtask

  task automatic junk_drive(input bit junk);
    if (junk) begin
      in_valid = 1'($urandom_range(0, 1));
      x_in = 22'($urandom);
      y_in = 22'($urandom);
      z_in = 22'($urandom);
    end
  endtask

  task automatic run_txn(input logic signed [21:0] x, y, z,
                         input int hold, input bit junk, input bit early);
    int c;
    accept(x, y, z);
    if (early) out_ready = 1;
    c = 1;
    while (!out_valid && c < 100) begin
      junk_drive(junk);
      @(posedge clk);
      #1;
      out_ready = 0;
      c++;
    end
    chk("latency", c, LAT);
    repeat (hold) begin
      junk_drive(junk);
      @(posedge clk);
      #1;
    end
    if (hold > 0) chk("busy_in_ready", in_ready, 0);
    out_ready = 1;
    if (junk) in_valid = 1;
    @(posedge clk);
    #1;
    out_ready = 0;
    in_valid = 0;
    chk("hs_out_valid", out_valid, 0);
    chk("hs_in_ready", in_ready, 1);
  endtask

  initial begin
    int v;
    @(posedge clk);
    #1;
    chk_en = 1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_x_out", x_out, 0);
    chk("rst_iter_cnt", iter_cnt, 0);
    rst = 0;
    @(posedge clk);
    #1;

    run_txn(22'sd262144, 22'sd0, 22'sd0, 0, 0, 0);
    chk_near("z0_x", x_out, KMAG, 32);
    chk_near("z0_y", y_out, 0, 32);
    chk_near("z0_z", z_out, 0, 32);

    run_txn(22'sd262144, 22'sd0, 22'sd1048576, 0, 0, 0);
    chk_near("hpi_x", x_out, 0, 32);
    chk_near("hpi_y", y_out, KMAG, 32);

    run_txn(22'sd262144, 22'sd0, -22'sd2097152, 0, 0, 1);
    chk_near("npi_x", x_out, -KMAG, 32);
    chk_near("npi_y", y_out, 0, 32);

    run_txn(22'sd100000, -22'sd50000, 22'sd300000, 5, 1, 0);

    accept(22'sd200000, 22'sd10000, 22'sd500000);
    repeat (7) @(posedge clk);
    #1;
    chk("mid_iter_cnt", iter_cnt, 7);
    rst = 1;
    @(posedge clk);
    #1;
    rst = 0;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    chk("mid_rst_x_out", x_out, 0);

    for (int t = 0; t < 40; t++) begin
      logic signed [21:0] rxi, ryi, rzi;
      v = int'($urandom_range(0, 1200000)) - 600000;
      rxi = 22'(v);
      v = int'($urandom_range(0, 1200000)) - 600000;
      ryi = 22'(v);
      rzi = 22'($urandom);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      run_txn(rxi, ryi, rzi, int'($urandom_range(0, 4)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    repeat (3) @(posedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
